aer_spike_encoder: RTL and testbench
====================================

Name: aer_spike_encoder

Overview:
Downstream consumer of the LIF neuron array. Latches single-cycle spike pulses from N neurons and stamps each with the current timestep. Round-robin arbitrates pending spikes into a small FWFT FIFO. Emits address-event (AER) packets {addr, ts} over a valid/ready handshake to the router/output serializer.

Parameters:
N_NEURONS, 8, number of spike inputs (power of 2, >=2)
ADDR_W, 3, log2(N_NEURONS), width of event address
TS_W, 8, timestep counter width
FIFO_DEPTH, 4, event FIFO entries (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
spike_in  in  N_NEURONS  per-neuron spike pulse, sampled every rising edge
tick  in  1  timestep strobe; advances timestamp counter
aer_valid  out  1  FIFO head valid
aer_ready  in  1  downstream accepts head when high with aer_valid
aer_addr  out  ADDR_W  neuron index of head event
aer_ts  out  TS_W  timestamp of head event
overflow  out  1  sticky: a spike was dropped
clear_ovf  in  1  clears overflow

Behaviour:
- Reset: clk is the clock; rst_n is a synchronous, active-low reset. With rst_n low at an edge: ts=0, pending=0, pending_ts=0, rr_ptr=0, FIFO empty, aer_valid=0, aer_addr=0, aer_ts=0, overflow=0. Mid-operation reset discards all pending and queued events.
- Timestamp: ts <= ts+1 on each edge with tick=1. Wraps 2^TS_W-1 -> 0.
- Capture: at each edge, for every i with spike_in[i]=1: pending[i]<=1, pending_ts[i]<=ts. The stamp is the pre-increment value when tick is in the same cycle.
- Pending update: pending_next = (pending & ~grant) | spike_in.
- Drop rule: spike_in[i] & pending[i] & ~grant[i] -> new spike is lost; old pending_ts kept; overflow<=1.
- Grant-and-respike on the same neuron in one cycle: the old event is queued, and the new event becomes pending with the new ts. No overflow.
- Arbiter: combinational one-hot grant, at most one per cycle. Grant is issued only if pending!=0 and FIFO count<FIFO_DEPTH.
- Search order: starts at rr_ptr and proceeds upward modulo N. After granting g, rr_ptr<=(g+1) mod N. rr_ptr is unchanged if there is no grant.
- Push: the granted {g, pending_ts[g]} is written to the FIFO at the same edge.
- Full FIFO: no grant, even if a pop occurs in the same cycle. Pending spikes wait (no loss unless re-spiked).
- FIFO: FWFT. aer_valid = count!=0. aer_addr/aer_ts = head entry, held stable while aer_valid & ~aer_ready.
- Pop: on aer_valid & aer_ready. Push and pop in the same cycle leave count unchanged. Order is strict FIFO.
- Latency: spike_in high at edge E0 with empty pending and FIFO -> pending after E0, grant and push at E1 -> aer_valid=1 after E1. That is 2 edges, and aer_addr=i.
- Throughput: 1 event/cycle sustained when aer_ready=1.
- overflow: sticky. overflow <= (overflow & ~clear_ovf) | drop_this_cycle. A set wins over a clear in the same cycle.
- Widths: ts arithmetic is unsigned modulo 2^TS_W. FIFO count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- snn_pkg: constants N_NEURONS, ADDR_W, TS_W, FIFO_DEPTH defaults; AER_W = ADDR_W+TS_W; event packing order {addr, ts} (addr in MSBs).
- Sub-module aer_fifo (parameterised width/depth, FWFT, push/pop/full/empty/count) instantiated once.
- The round-robin arbiter stays inline.

Test Plan:
- Reset: hold rst_n=0 3 cycles with spike_in=8'hFF, tick=1 -> aer_valid=0, overflow=0. Release and check ts=0 by spiking neuron 2 -> event {2, 0}.
- Single spike: ts=5, spike_in=8'h08 one cycle, aer_ready=1 -> aer_valid high exactly 1 cycle after 2 edges, aer_addr=3, aer_ts=5.
- Round robin: rr_ptr=0, spike_in=8'hA5 one cycle, aer_ready=1 -> events in addr order 0, 2, 5, 7 on consecutive cycles, all with the same ts.
- Backpressure/full: aer_ready=0, spike all 8 neurons -> FIFO holds 4 (addrs 0-3) and head stays stable. Raise aer_ready -> 8 events in order 0..7, no overflow.
- Drop: aer_ready=0, fill FIFO, then spike neuron 4 at ts=1 and again at ts=2 -> overflow=1, queued event shows ts=1. Pulse clear_ovf -> overflow=0. Clear coincident with a new drop -> overflow stays 1.
- Wrap/same-cycle: ts=255 with tick=1 and spike neuron 1 -> stamp 255, next ts=0. Re-spike a neuron in its grant cycle -> two events, no overflow.

Source files
------------

// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared constants and types for the spiking-network event path.
//   N_NEURONS  : default number of spike inputs (power of 2, >= 2)
//   ADDR_W     : default event address width, log2(N_NEURONS)
//   TS_W       : default timestep counter width
//   FIFO_DEPTH : default event FIFO entries (power of 2)
//   AER_W      : packed event width, {addr, ts} with addr in the MSBs
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package snn_pkg;

    localparam int N_NEURONS  = 8;
    localparam int ADDR_W     = 3;
    localparam int TS_W       = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int AER_W      = ADDR_W + TS_W;

    // Address-event packet at the default widths; addr occupies the MSBs.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TS_W-1:0]   ts;
    } aer_event_t;

endpackage

// File: rtl/aer_fifo.sv
// ---------------------------------------------------------------------------
// aer_fifo
// First-word-fall-through FIFO for address-event packets. The head entry is
// visible on pop_data whenever empty is low; pop consumes it.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   push        : write push_data (ignored when full)
//   push_data   : WIDTH-bit entry to write
//   pop         : consume the head entry (ignored when empty)
//   pop_data    : head entry (meaningful only while empty is low)
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module aer_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of 2.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; entries are only observable
    // through count, which is reset, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/aer_spike_encoder.sv
// ---------------------------------------------------------------------------
// aer_spike_encoder
// Latches single-cycle spike pulses from N_NEURONS neurons, stamps each with
// the current timestep, round-robin arbitrates pending spikes into an event
// FIFO and emits {addr, ts} address events over a valid/ready handshake.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   spike_in   : per-neuron spike pulse, sampled every rising edge
//   tick       : timestep strobe, advances the timestamp counter
//   aer_valid  : FIFO head valid
//   aer_ready  : downstream accepts the head when high with aer_valid
//   aer_addr   : neuron index of the head event (0 while idle)
//   aer_ts     : timestamp of the head event (0 while idle)
//   overflow   : sticky, a spike was dropped
//   clear_ovf  : clears overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module aer_spike_encoder #(
    parameter int N_NEURONS  = snn_pkg::N_NEURONS,
    parameter int ADDR_W     = snn_pkg::ADDR_W,
    parameter int TS_W       = snn_pkg::TS_W,
    parameter int FIFO_DEPTH = snn_pkg::FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 tick,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic [ADDR_W-1:0]    aer_addr,
    output logic [TS_W-1:0]      aer_ts,
    output logic                 overflow,
    input  logic                 clear_ovf
);

    localparam int AER_W = ADDR_W + TS_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [TS_W-1:0]      ts;
    logic [N_NEURONS-1:0] pending;
    logic [TS_W-1:0]      pending_ts [N_NEURONS];
    logic [ADDR_W-1:0]    rr_ptr;

    logic                 grant_valid;
    logic [ADDR_W-1:0]    grant_idx;
    logic [N_NEURONS-1:0] grant;
    logic [N_NEURONS-1:0] drop;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count_unused;
    logic [AER_W-1:0]     fifo_head;

    // Round-robin search: first pending neuron at or above rr_ptr, modulo N.
    // No grant while the FIFO is full, even if it pops this cycle.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        logic [ADDR_W-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        if (!fifo_full) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                idx = rr_ptr + ADDR_W'(k);
                if (pending[idx] && !grant_valid) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx;
                end
            end
        end
    end

    assign grant = grant_valid ? (N_NEURONS'(1) << grant_idx) : '0;

    // A new spike on a neuron that stays pending is lost. A granted neuron
    // frees its slot this cycle, so a re-spike there is kept.
    assign drop = spike_in & pending & ~grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts       <= '0;
            pending  <= '0;
            rr_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) pending_ts[i] <= '0;
        end else begin
            if (tick) ts <= ts + TS_W'(1);
            pending <= (pending & ~grant) | spike_in;
            // Stamp with the pre-increment ts; dropped spikes keep the old stamp.
            for (int i = 0; i < N_NEURONS; i++) begin
                if (spike_in[i] && !drop[i]) pending_ts[i] <= ts;
            end
            if (grant_valid) rr_ptr <= grant_idx + ADDR_W'(1);
            overflow <= (overflow & ~clear_ovf) | (|drop);
        end
    end

    aer_fifo #(
        .WIDTH (AER_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant_valid),
        .push_data ({grant_idx, pending_ts[grant_idx]}),
        .pop       (aer_ready),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_unused)
    );

    // Head fields are forced to zero while idle so stale storage never shows.
    assign aer_valid = !fifo_empty;
    assign aer_addr  = aer_valid ? fifo_head[AER_W-1:TS_W] : '0;
    assign aer_ts    = aer_valid ? fifo_head[TS_W-1:0]     : '0;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// ---------------------------------------------------------------------------
// tb_aer_spike_encoder
// Scoreboard bench for aer_spike_encoder. A behavioural model advances on
// each rising edge and queues the events it expects; a monitor on the
// falling edge compares aer_valid, overflow and the head event against it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aer_spike_encoder;
    import snn_pkg::*;

    bit                   clk = 1'b0;
    logic                 rst_n;
    logic [N_NEURONS-1:0] spike_in;
    logic                 tick;
    logic                 aer_valid;
    logic                 aer_ready;
    logic [ADDR_W-1:0]    aer_addr;
    logic [TS_W-1:0]      aer_ts;
    logic                 overflow;
    logic                 clear_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    aer_spike_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spike_in  (spike_in),
        .tick      (tick),
        .aer_valid (aer_valid),
        .aer_ready (aer_ready),
        .aer_addr  (aer_addr),
        .aer_ts    (aer_ts),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    aer_event_t exp_q[$];
    int         m_ts;
    bit         m_pend [N_NEURONS];
    int         m_pts  [N_NEURONS];
    int         m_rr;
    int         m_cnt;
    bit         m_ovf;

    always @(posedge clk) begin
        int g;
        bit lost;
        bit popped;
        aer_event_t ev;
        if (!rst_n) begin
            m_ts = 0; m_rr = 0; m_cnt = 0; m_ovf = 0;
            for (int i = 0; i < N_NEURONS; i++) begin
                m_pend[i] = 0;
                m_pts[i]  = 0;
            end
            exp_q.delete();
        end else begin
            g = -1;
            if (m_cnt < FIFO_DEPTH) begin
                for (int k = 0; k < N_NEURONS; k++) begin
                    int j;
                    j = (m_rr + k) % N_NEURONS;
                    if (g < 0 && m_pend[j]) g = j;
                end
            end
            popped = (m_cnt > 0) && aer_ready;
            if (g >= 0) begin
                ev.addr = ADDR_W'(g);
                ev.ts   = TS_W'(m_pts[g]);
                exp_q.push_back(ev);
                m_pend[g] = 0;
                m_rr = (g + 1) % N_NEURONS;
            end
            lost = 0;
            for (int i = 0; i < N_NEURONS; i++) begin
                if (spike_in[i]) begin
                    if (m_pend[i]) lost = 1;
                    else begin
                        m_pend[i] = 1;
                        m_pts[i]  = m_ts;
                    end
                end
            end
            m_ovf = (m_ovf && !clear_ovf) || lost;
            m_cnt = m_cnt + (g >= 0 ? 1 : 0) - (popped ? 1 : 0);
            if (tick) m_ts = (m_ts + 1) % (1 << TS_W);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        check("aer_valid", aer_valid, m_cnt != 0);
        check("overflow", overflow, m_ovf);
        if (m_cnt != 0 && exp_q.size() != 0) begin
            check("head_addr", aer_addr, exp_q[0].addr);
            check("head_ts", aer_ts, exp_q[0].ts);
            if (aer_ready) void'(exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [N_NEURONS-1:0] s, input logic t, input logic r, input logic c);
        spike_in  = s;
        tick      = t;
        aer_ready = r;
        clear_ovf = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step('0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int rr_exp [4] = '{0, 2, 5, 7};
        rst_n = 1'b0; spike_in = '0; tick = 1'b0; aer_ready = 1'b0; clear_ovf = 1'b0;

        // Reset held with all spikes and tick active.
        repeat (3) step('1, 1'b1, 1'b1, 1'b0);
        check("rst_valid", aer_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_addr", aer_addr, 0);
        check("rst_ts", aer_ts, 0);
        rst_n = 1'b1;
        step(8'h04, 1'b0, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        check("post_rst_valid", aer_valid, 1);
        check("post_rst_addr", aer_addr, 2);
        check("post_rst_ts", aer_ts, 0);
        step(8'h00, 1'b0, 1'b1, 1'b0);

        // Single spike at ts=5: visible after exactly two edges, for one cycle.
        do_reset();
        repeat (5) step(8'h00, 1'b1, 1'b1, 1'b0);
        step(8'h08, 1'b0, 1'b1, 1'b0);
        check("single_early", aer_valid, 0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        check("single_valid", aer_valid, 1);
        check("single_addr", aer_addr, 3);
        check("single_ts", aer_ts, 5);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        check("single_gone", aer_valid, 0);

        // Round robin from rr_ptr=0.
        do_reset();
        step(8'hA5, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(8'h00, 1'b0, 1'b1, 1'b0);
            check("rr_addr", aer_addr, rr_exp[i]);
        end
        step(8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure: FIFO fills with 0..3, head stays put, then drains all 8.
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (6) step(8'h00, 1'b0, 1'b0, 1'b0);
        check("bp_addr", aer_addr, 0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        check("bp_hold", aer_addr, 0);
        repeat (12) step(8'h00, 1'b0, 1'b1, 1'b0);
        check("bp_ovf", overflow, 0);

        // Drop, clear, clear coincident with a drop.
        do_reset();
        step(8'h0F, 1'b1, 1'b0, 1'b0);
        repeat (5) step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h10, 1'b1, 1'b0, 1'b0);
        step(8'h10, 1'b0, 1'b0, 1'b0);
        check("drop_set", overflow, 1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        check("drop_clear", overflow, 0);
        step(8'h10, 1'b0, 1'b0, 1'b1);
        check("drop_beats_clear", overflow, 1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        repeat (4) step(8'h00, 1'b0, 1'b1, 1'b0);
        check("drop_kept_addr", aer_addr, 4);
        check("drop_kept_ts", aer_ts, 1);
        repeat (3) step(8'h00, 1'b0, 1'b1, 1'b0);

        // Timestamp wrap and same-cycle grant/re-spike.
        do_reset();
        repeat (255) step(8'h00, 1'b1, 1'b1, 1'b0);
        step(8'h02, 1'b1, 1'b1, 1'b0);
        step(8'h01, 1'b0, 1'b1, 1'b0);
        check("wrap_addr", aer_addr, 1);
        check("wrap_ts", aer_ts, 255);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        check("wrapped_addr", aer_addr, 0);
        check("wrapped_ts", aer_ts, 0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        step(8'h40, 1'b0, 1'b1, 1'b0);
        step(8'h40, 1'b0, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        check("respike_valid", aer_valid, 1);
        check("respike_addr", aer_addr, 6);
        check("respike_ovf", overflow, 0);
        repeat (3) step(8'h00, 1'b0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            step(N_NEURONS'($urandom & $urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
        end
        rst_n = 1'b1;
        repeat (20) step(8'h00, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
